// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between a host (master) and the register bank (slave).
interface spi_reg_bank_if;
    logic sclk;
    logic ncs;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output sclk, output ncs, output mosi, input miso, input miso_oe);
    modport slave  (input sclk, input ncs, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave fronting NUM_REGS control registers. SCLK is only ever
// sampled; every flop runs on clk. Frame: R/W bit, address, data, MSB first.
module spi_reg_bank #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    spi_reg_bank_if.slave              spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);
    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CW        = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST_HDR   = CW'(ADDR_W);
    localparam logic [CW-1:0] FIRST_DATA = CW'(ADDR_W + 1);
    localparam logic [CW-1:0] LAST_BIT   = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] FULL       = CW'(FRAME_LEN);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT_END} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync, mosi_sync;
    logic                   sclk_d, ncs_d, mosi_d;
    logic [SYNC_STAGES:0]   vld_pipe;
    logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall;

    state_t                            state, state_n;
    logic [CW-1:0]                     cnt, cnt_n;
    logic [ADDR_W:0]                   hdr, hdr_n;
    logic [DATA_W-1:0]                 rxd, rxd_n;
    logic [DATA_W-1:0]                 tx, tx_n;
    logic                              overrun, ovr_n;
    logic                              do_wr, err, oe_n;
    logic [NUM_REGS-1:0][DATA_W-1:0]   regs;

    assign regs_flat = regs;

    // Input synchronisers plus one delay flop each for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            ncs_sync  <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ncs_d     <= 1'b1;
            mosi_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ncs_d     <= ncs_sync[SYNC_STAGES-1];
            mosi_d    <= mosi_sync[SYNC_STAGES-1];
        end
    end

    // Edges are only trusted once the chain holds real pin samples, so a
    // chip select already low when reset releases never looks like a fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            ncs_rise  <= 1'b0;
            ncs_fall  <= 1'b0;
        end else begin
            vld_pipe  <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
            sclk_rise <= vld_pipe[SYNC_STAGES] &  sclk_sync[SYNC_STAGES-1] & ~sclk_d;
            sclk_fall <= vld_pipe[SYNC_STAGES] & ~sclk_sync[SYNC_STAGES-1] &  sclk_d;
            ncs_rise  <= vld_pipe[SYNC_STAGES] &  ncs_sync[SYNC_STAGES-1]  & ~ncs_d;
            ncs_fall  <= vld_pipe[SYNC_STAGES] & ~ncs_sync[SYNC_STAGES-1]  &  ncs_d;
        end
    end

    // Frame FSM: next state, shift registers and commit/abort decision.
    // mosi_d lines up with the registered sclk edge flags.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hdr_n   = hdr;
        rxd_n   = rxd;
        tx_n    = tx;
        ovr_n   = overrun;
        do_wr   = 1'b0;
        err     = 1'b0;
        if (ncs_rise) begin
            // chip-select release wins over any sclk edge in the same cycle
            state_n = IDLE;
            if (state != IDLE) begin
                if (cnt != FULL || overrun)
                    err = 1'b1;
                else if (hdr[ADDR_W] && int'(hdr[ADDR_W-1:0]) < NUM_REGS)
                    do_wr = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (ncs_fall) begin
                        state_n = ADDR;
                        cnt_n   = '0;
                        ovr_n   = 1'b0;
                    end
                end
                ADDR: begin
                    if (sclk_rise) begin
                        hdr_n = {hdr[ADDR_W-1:0], mosi_d};
                        cnt_n = cnt + 1'b1;
                        if (cnt == LAST_HDR) begin
                            state_n = DATA;
                            tx_n    = '0;
                            for (int i = 0; i < NUM_REGS; i++)
                                if (int'(hdr_n[ADDR_W-1:0]) == i) tx_n = regs[i];
                        end
                    end
                end
                DATA: begin
                    if (sclk_rise) begin
                        rxd_n = {rxd[DATA_W-2:0], mosi_d};
                        cnt_n = cnt + 1'b1;
                        if (cnt == LAST_BIT) state_n = WAIT_END;
                    end else if (sclk_fall && cnt != FIRST_DATA) begin
                        // the fall right after the last address bit keeps the
                        // MSB on the line for the first data rise
                        tx_n = {tx[DATA_W-2:0], 1'b0};
                    end
                end
                WAIT_END: begin
                    if (sclk_rise) ovr_n = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
        oe_n = (state_n == DATA) && !hdr_n[ADDR_W];
    end

    // Frame state and shift registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            hdr     <= '0;
            rxd     <= '0;
            tx      <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            hdr     <= hdr_n;
            rxd     <= rxd_n;
            tx      <= tx_n;
            overrun <= ovr_n;
        end
    end

    // Registered outputs: register file, strobes and the MISO driver.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs        <= '0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            frame_err   <= 1'b0;
            spi.miso    <= 1'b0;
            spi.miso_oe <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (do_wr && int'(hdr[ADDR_W-1:0]) == i) regs[i] <= rxd;
            wr_strobe   <= do_wr;
            if (do_wr) wr_addr <= hdr[ADDR_W-1:0];
            frame_err   <= err;
            spi.miso_oe <= oe_n;
            spi.miso    <= oe_n ? tx_n[DATA_W-1] : 1'b0;
        end
    end
endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: default instance (a) and a wide-parameter
// instance (b) sharing one bit-banged SPI host selected by 'sel'.
module tb_spi_reg_bank;
    localparam int H  = 6;   // sclk half period in clk cycles
    localparam int SA = 2;
    localparam int SB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk_p = 1'b0, ncs_p = 1'b1, mosi_p = 1'b0, sel = 1'b0;

    spi_reg_bank_if ifa ();
    spi_reg_bank_if ifb ();

    logic [39:0]  regs_a;
    logic [191:0] regs_b;
    logic         stb_a, stb_b, err_a, err_b;
    logic [6:0]   wa_a;
    logic [3:0]   wa_b;
    logic         miso_m, oe_m;

    assign ifa.sclk = sel ? 1'b0 : sclk_p;
    assign ifa.ncs  = sel ? 1'b1 : ncs_p;
    assign ifa.mosi = sel ? 1'b0 : mosi_p;
    assign ifb.sclk = sel ? sclk_p : 1'b0;
    assign ifb.ncs  = sel ? ncs_p  : 1'b1;
    assign ifb.mosi = sel ? mosi_p : 1'b0;
    assign miso_m   = sel ? ifb.miso    : ifa.miso;
    assign oe_m     = sel ? ifb.miso_oe : ifa.miso_oe;

    spi_reg_bank u_a (
        .clk(clk), .rst(rst), .spi(ifa), .regs_flat(regs_a),
        .wr_strobe(stb_a), .wr_addr(wa_a), .frame_err(err_a)
    );

    spi_reg_bank #(.ADDR_W(4), .DATA_W(16), .NUM_REGS(12), .SYNC_STAGES(SB)) u_b (
        .clk(clk), .rst(rst), .spi(ifb), .regs_flat(regs_b),
        .wr_strobe(stb_b), .wr_addr(wa_b), .frame_err(err_b)
    );

    always #5 clk = ~clk;

    int nchk = 0, nfail = 0;
    int stb_cnt [2];
    int err_cnt [2];
    int last_wa [2];
    logic [15:0] mdl [2][16];

    initial begin
        for (int k = 0; k < 2; k++) begin
            stb_cnt[k] = 0; err_cnt[k] = 0; last_wa[k] = 0;
        end
    end

    // pulse counters for the one-clk strobes
    always @(negedge clk) begin
        if (stb_a) begin stb_cnt[0] = stb_cnt[0] + 1; last_wa[0] = int'(wa_a); end
        if (stb_b) begin stb_cnt[1] = stb_cnt[1] + 1; last_wa[1] = int'(wa_b); end
        if (err_a) err_cnt[0] = err_cnt[0] + 1;
        if (err_b) err_cnt[1] = err_cnt[1] + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_model();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++) mdl[k][i] = '0;
    endtask

    task automatic chk_regs(input int inst);
        if (inst == 0)
            for (int i = 0; i < 5; i++) chk("regs_a", regs_a[i*8 +: 8], mdl[0][i][7:0]);
        else
            for (int i = 0; i < 12; i++) chk("regs_b", regs_b[i*16 +: 16], mdl[1][i]);
    endtask

    // Bit-bang one frame of nbits; bits beyond the frame length send 0.
    // Captures miso before each data rise and counts miso_oe deviations.
    task automatic run_frame(input int inst, input int nbits, input logic [31:0] bits,
                             input bit lat, output logic [15:0] rd, output int oe_bad);
        int fl, aw;
        logic rw, exp_oe;
        aw = inst ? 4 : 7;
        fl = inst ? 21 : 16;
        rw = bits[fl-1];
        rd = '0;
        oe_bad = 0;
        sel = inst[0];
        cyc(H);
        ncs_p = 1'b0;
        cyc(H);
        for (int i = 0; i < nbits; i++) begin
            mosi_p = (i < fl) ? bits[fl-1-i] : 1'b0;
            cyc(H);
            exp_oe = (!rw && i >= 1 + aw && i < fl);
            if (oe_m !== exp_oe) oe_bad++;
            if (i >= 1 + aw && i < fl) rd = {rd[14:0], miso_m};
            sclk_p = 1'b1;
            cyc(H);
            sclk_p = 1'b0;
        end
        cyc(H);
        ncs_p = 1'b1;
        if (lat) begin
            // register must still hold the old value SA+1 cycles in, new one after SA+2
            repeat (SA + 2) @(negedge clk);
            chk("latency early", regs_a[7:0], mdl[0][0][7:0]);
            @(negedge clk);
            chk("latency reg", regs_a[7:0], bits[7:0]);
            chk("latency strobe", stb_a, 1'b1);
        end
        cyc(H + SB + 4);
        if (oe_m !== 1'b0 || miso_m !== 1'b0) oe_bad++;
    endtask

    // One frame checked against the frame-level reference model.
    task automatic do_frame(input int inst, input int nbits, input logic rw, input int addr,
                            input logic [15:0] data, input bit lat,
                            output int n_err, output int n_stb, output logic [15:0] rd);
        int aw, dw, n, fl, e0, s0, oe_bad;
        logic [31:0] bits;
        logic m_err, m_wr;
        logic [15:0] m_rd;
        aw = inst ? 4 : 7;
        dw = inst ? 16 : 8;
        n  = inst ? 12 : 5;
        fl = 1 + aw + dw;
        bits = (32'(rw) << (aw + dw)) | (32'(addr) << dw) | 32'(data);
        m_err = (nbits != fl);
        m_wr  = !m_err && rw && addr < n;
        m_rd  = (addr < n) ? mdl[inst][addr] : 16'h0;
        e0 = err_cnt[inst];
        s0 = stb_cnt[inst];
        run_frame(inst, nbits, bits, lat, rd, oe_bad);
        n_err = err_cnt[inst] - e0;
        n_stb = stb_cnt[inst] - s0;
        chk("frame_err pulses", n_err, m_err);
        chk("wr_strobe pulses", n_stb, m_wr);
        if (m_wr) chk("wr_addr", last_wa[inst], addr);
        if (!rw && nbits >= fl) chk("miso word", rd, m_rd);
        chk("miso_oe samples off", oe_bad, 0);
        if (m_wr) mdl[inst][addr] = data;
        chk_regs(inst);
    endtask

    typedef struct {
        int          inst;
        int          nbits;
        logic        rw;
        int          addr;
        logic [15:0] data;
        logic        exp_err;
        logic        exp_stb;
        logic        chk_rd;
        logic [15:0] exp_rd;
    } vec_t;

    initial begin
        vec_t v [13];
        int ne, ns, inst, kind, nb, fl, ad;
        logic [15:0] rd, dat;
        logic rw;
        logic [31:0] bits;
        int e0, s0, oe_bad;

        v[0]  = '{0, 16, 1'b1, 0,  16'h00A5, 1'b0, 1'b1, 1'b0, 16'h0};
        v[1]  = '{0, 16, 1'b1, 0,  16'h0011, 1'b0, 1'b1, 1'b0, 16'h0};
        v[2]  = '{0, 16, 1'b1, 1,  16'h0022, 1'b0, 1'b1, 1'b0, 16'h0};
        v[3]  = '{0, 16, 1'b1, 2,  16'h0033, 1'b0, 1'b1, 1'b0, 16'h0};
        v[4]  = '{0, 16, 1'b1, 3,  16'h0044, 1'b0, 1'b1, 1'b0, 16'h0};
        v[5]  = '{0, 16, 1'b1, 4,  16'h0055, 1'b0, 1'b1, 1'b0, 16'h0};
        v[6]  = '{0, 16, 1'b0, 3,  16'h0000, 1'b0, 1'b0, 1'b1, 16'h0044};
        v[7]  = '{0, 16, 1'b1, 9,  16'h00FF, 1'b0, 1'b0, 1'b0, 16'h0};
        v[8]  = '{0, 16, 1'b0, 9,  16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
        v[9]  = '{0, 10, 1'b1, 2,  16'h00EE, 1'b1, 1'b0, 1'b0, 16'h0};
        v[10] = '{0, 17, 1'b1, 1,  16'h0099, 1'b1, 1'b0, 1'b0, 16'h0};
        v[11] = '{1, 21, 1'b1, 11, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'h0};
        v[12] = '{1, 21, 1'b0, 11, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hBEEF};

        clr_model();
        cyc(4);
        // reset values while reset is held
        chk("reset regs_a", regs_a, 40'h0);
        chk("reset regs_b hi", regs_b[191:128], 64'h0);
        chk("reset strobes", {stb_a, stb_b, err_a, err_b}, 4'h0);
        chk("reset wr_addr", {wa_a, wa_b}, 11'h0);
        chk("reset miso", {ifa.miso, ifa.miso_oe, ifb.miso, ifb.miso_oe}, 4'h0);
        rst = 1'b0;
        cyc(10);

        for (int k = 0; k < 13; k++) begin
            do_frame(v[k].inst, v[k].nbits, v[k].rw, v[k].addr, v[k].data, k == 0, ne, ns, rd);
            chk("tbl frame_err", ne, v[k].exp_err);
            chk("tbl wr_strobe", ns, v[k].exp_stb);
            if (v[k].chk_rd) chk("tbl miso word", rd, v[k].exp_rd);
        end
        chk("b reg11", regs_b[191:176], 16'hBEEF);

        // reset in the middle of a write's data phase with ncs held low
        sel = 1'b0;
        bits = 32'h8000 | (32'd2 << 8) | 32'h77;
        cyc(H);
        ncs_p = 1'b0;
        cyc(H);
        for (int i = 0; i < 12; i++) begin
            mosi_p = bits[15-i];
            cyc(H); sclk_p = 1'b1; cyc(H); sclk_p = 1'b0;
        end
        rst = 1'b1;
        cyc(3);
        chk("midrst regs_a", regs_a, 40'h0);
        chk("midrst regs_b", regs_b[63:0], 64'h0);
        chk("midrst outputs", {stb_a, err_a, ifa.miso, ifa.miso_oe, wa_a}, 11'h0);
        rst = 1'b0;
        clr_model();
        e0 = err_cnt[0];
        s0 = stb_cnt[0];
        for (int i = 12; i < 16; i++) begin
            mosi_p = bits[15-i];
            cyc(H); sclk_p = 1'b1; cyc(H); sclk_p = 1'b0;
        end
        cyc(H);
        ncs_p = 1'b1;
        cyc(H + 8);
        oe_bad = (ifa.miso_oe !== 1'b0) ? 1 : 0;
        chk("midrst tail err", err_cnt[0] - e0, 0);
        chk("midrst tail stb", stb_cnt[0] - s0, 0);
        chk("midrst tail oe", oe_bad, 0);
        chk("midrst tail regs", regs_a, 40'h0);
        do_frame(0, 16, 1'b1, 2, 16'h0077, 1'b0, ne, ns, rd);
        chk("post-reset commit", regs_a[23:16], 8'h77);

        // randomized frames against the model
        for (int k = 0; k < 30; k++) begin
            inst = int'($urandom_range(0, 1));
            fl   = inst ? 21 : 16;
            kind = int'($urandom_range(0, 9));
            nb   = (kind == 0) ? int'($urandom_range(1, fl - 1)) :
                   (kind == 1) ? fl + int'($urandom_range(1, 2)) : fl;
            rw   = 1'($urandom_range(0, 1));
            ad   = int'($urandom_range(0, inst ? 14 : 7));
            dat  = 16'($urandom);
            if (inst == 0) dat[15:8] = 8'h0;
            do_frame(inst, nb, rw, ad, dat, 1'b0, ne, ns, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Parametrised, fully clk-synchronous SPI peripheral (mode 0) fronting a bank of NUM_REGS control registers.
- Adds read-back over MISO, framing-error detection, a per-write strobe, and configurable address/data width and synchroniser depth.
- Sits between the chip pins and the output-enable/PWM configuration logic.
- SCLK is never used as a clock; all logic runs on clk.

Parameters:
- ADDR_W, 7, address field width in bits.
- DATA_W, 8, data field and register width in bits.
- NUM_REGS, 5, number of implemented registers; valid addresses are 0..NUM_REGS-1.
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers (minimum 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- sclk  input  1  SPI clock, asynchronous to clk.
- ncs  input  1  SPI chip select, active low, asynchronous to clk.
- mosi  input  1  SPI data in.
- miso  output  1  SPI data out.
- miso_oe  output  1  high while the chip is selected and a read data phase is active.
- regs_flat  output  NUM_REGS*DATA_W  register contents; reg i occupies bits [i*DATA_W +: DATA_W].
- wr_strobe  output  1  one-clk pulse on each committed write.
- wr_addr  output  ADDR_W  address of the last committed write; valid while wr_strobe is high.
- frame_err  output  1  one-clk pulse when a frame is aborted.

Behaviour:
- Reset:
  - Asynchronous, active-high: clk and one asynchronous active-high reset (rst).
  - Reset values: regs_flat=0, miso=0, miso_oe=0, wr_strobe=0, wr_addr=0, frame_err=0, FSM=IDLE, bit counter=0.
  - Synchroniser flops reset to: ncs=1, sclk=0, mosi=0.
- Synchronisers and edge detection:
  - Each of sclk, ncs and mosi passes through SYNC_STAGES flops.
  - One extra flop per signal provides edge detection on the synchronised values.
- Frame format: MSB first, FRAME_LEN = 1+ADDR_W+DATA_W bits.
  - Bit 0 is R/W (1 = write, 0 = read).
  - Next ADDR_W bits are the address.
  - Next DATA_W bits are the data.
  - mosi is sampled on each synchronised sclk rising edge.
- FSM states: IDLE, ADDR, DATA, WAIT_END.
  - IDLE -> ADDR on a synchronised ncs falling edge; the bit counter is cleared. Holding ncs low without an edge (e.g. after reset) does NOT start a frame.
  - ADDR: captures R/W and address bits. Transitions to DATA on the sclk rise that samples the last address bit.
  - On entering DATA in a read, the shift register loads reg[addr], or 0 if addr >= NUM_REGS. miso presents its MSB on the next clk, and miso_oe goes high.
  - DATA: shifts data in. For a read, miso advances one bit on each synchronised sclk falling edge. After bit FRAME_LEN-1 is sampled, go to WAIT_END.
  - WAIT_END: any further sclk rise sets an overrun flag.
  - On a synchronised ncs rising edge, any state returns to IDLE.
- Commit on the ncs rising edge:
  - Conditions: write bit=1, bit count == FRAME_LEN, no overrun, addr < NUM_REGS.
  - When all hold, the register updates and wr_strobe pulses on the clk edge after edge detection. Latency from the ncs pin rising to the register update is SYNC_STAGES+2 clk cycles.
  - Writes to addr >= NUM_REGS are dropped silently (no strobe, no error).
- frame_err pulses (no write) on an ncs rise when bit count < FRAME_LEN (a short frame, including ncs rising mid-ADDR) or when overrun is set.
- A read frame never writes. A complete read frame gives no strobe and no error.
- Simultaneous events: if a synchronised sclk edge and an ncs rising edge are detected in the same clk, the ncs edge wins and the sclk edge is discarded.
- miso_oe drops and miso goes to 0 on the ncs rising edge.
- Timing constraint on the host: the sclk high and low phases must each be >= SYNC_STAGES+2 clk periods. Behaviour is undefined below that.
- Reset mid-frame: the frame is discarded, no strobe or error is produced, and the next frame requires a fresh ncs falling edge.

Test Plan:
- Write addr 0 data 0xA5 (frame 1_0000000_10100101), ncs high -> regs_flat[7:0]=0xA5 SYNC_STAGES+2 clks after the ncs rise; wr_strobe one pulse; wr_addr=0; frame_err=0.
- Write all 5 regs (0x11..0x55), then read addr 3 -> miso shifts out 0x44 MSB-first on 8 falling edges; miso_oe high only during DATA; no register changes.
- Write addr 9 data 0xFF -> no register change, no wr_strobe, no frame_err. Read addr 9 -> miso returns 0x00.
- Short write: ncs rises after 10 bits -> frame_err one pulse; regs unchanged. Overrun: 17 sclk pulses on a write -> frame_err; no write.
- rst pulsed mid-DATA of a write while ncs stays low -> all outputs reset; further sclk pulses ignored. The next full frame after a new ncs fall commits correctly.
- Parameter sweep ADDR_W=4, DATA_W=16, NUM_REGS=12, SYNC_STAGES=3: write addr 11 data 0xBEEF, then read it back -> regs_flat[191:176]=0xBEEF; miso returns 0xBEEF.
